// File: rtl/lsu_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl_pkg
//   Shared definitions for the load/store sequencer: the FSM state encoding
//   and the default width / timeout values used by lsu_mem_ctrl.
// -----------------------------------------------------------------------------
package lsu_mem_ctrl_pkg;

    localparam int LSU_DW      = 16;
    localparam int LSU_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_addr_gen.sv
// -----------------------------------------------------------------------------
// lsu_addr_gen
//   Effective address former for M-type instructions: base plus the
//   sign-extended 4-bit offset. The sum wraps modulo 2^DW with no flag.
// Ports:
//   base  in  DW  base register value
//   imm4  in  4   signed offset field
//   ea    out DW  effective address
// -----------------------------------------------------------------------------
module lsu_addr_gen #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] base,
    input  logic [3:0]    imm4,
    output logic [DW-1:0] ea
);

    assign ea = base + {{(DW-4){imm4[3]}}, imm4};

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store sequencer. Captures a request from decode, forms the effective
//   address, runs a req/ack handshake with data memory (wait states allowed,
//   aborted after TIMEOUT unacknowledged cycles), writes load data back to the
//   register file and holds busy so fetch stalls until the access completes.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, is_store, base, imm4,   request from decode, sampled only in IDLE
//   st_data, rd_addr
//   mem_req, mem_we, mem_addr,     memory request side, all zero when idle
//   mem_wdata
//   mem_ack, mem_rdata             memory completion and load data
//   busy                           high in every state except IDLE
//   wb_en, wb_addr, wb_data        one-cycle register-file write (loads)
//   done                           one-cycle completion pulse
//   err                            one-cycle timeout abort pulse
// -----------------------------------------------------------------------------
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT,
    parameter int DW      = LSU_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_store,
    input  logic [DW-1:0] base,
    input  logic [3:0]    imm4,
    input  logic [DW-1:0] st_data,
    input  logic [3:0]    rd_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          wb_en,
    output logic [3:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          done,
    output logic          err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    lsu_state_t    state;
    logic          lat_store;
    logic [DW-1:0] lat_base;
    logic [3:0]    lat_imm4;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    lat_rd;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] ea_next;

    lsu_addr_gen #(.DW(DW)) u_addr_gen (
        .base (lat_base),
        .imm4 (lat_imm4),
        .ea   (ea_next)
    );

    // busy comes straight from the state register so an async reset
    // releases the fetch stall immediately.
    assign busy = (state != IDLE);

    // Sequencer FSM. mem_addr doubles as the registered effective address;
    // it and the other memory-side outputs are loaded on the ADDR->REQ edge
    // and cleared on leaving REQ, so they read zero whenever mem_req is low.
    // done/wb_*/err are one-cycle pulses: cleared by default every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_store <= 1'b0;
            lat_base  <= '0;
            lat_imm4  <= '0;
            lat_wdata <= '0;
            lat_rd    <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        lat_store <= is_store;
                        lat_base  <= base;
                        lat_imm4  <= imm4;
                        lat_wdata <= st_data;
                        lat_rd    <= rd_addr;
                        state     <= ADDR;
                    end
                end

                ADDR: begin
                    wait_cnt  <= '0;
                    mem_req   <= 1'b1;
                    mem_we    <= lat_store;
                    mem_addr  <= ea_next;
                    mem_wdata <= lat_store ? lat_wdata : '0;
                    state     <= REQ;
                end

                REQ: begin
                    // Ack is checked first so it wins over the timeout limit.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        done      <= 1'b1;
                        wb_en     <= ~lat_store;
                        wb_addr   <= lat_store ? 4'd0 : lat_rd;
                        wb_data   <= lat_store ? '0 : mem_rdata;
                        state     <= DONE;
                    end else if (wait_cnt == CNT_LIMIT) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Self-checking bench for lsu_mem_ctrl (built with TIMEOUT=8). Expected
//   addresses come from signed integer arithmetic, expected handshake length
//   from the number of wait states the bench itself inserts.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] base = '0;
    logic [3:0]  imm4 = '0;
    logic [15:0] st_data = '0;
    logic [3:0]  rd_addr = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_ctrl #(.TIMEOUT(TO), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .base      (base),
        .imm4      (imm4),
        .st_data   (st_data),
        .rd_addr   (rd_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: effective address is base plus signed offset, modulo 2^16.
    function automatic logic [15:0] model_ea(input logic [15:0] b, input logic [3:0] imm);
        int off;
        off = imm[3] ? int'(imm) - 16 : int'(imm);
        return 16'(int'(b) + off);
    endfunction

    // One complete access starting with the DUT idle, #1 after a rising edge.
    // waits >= TO means memory never acknowledges. hold_start keeps start high
    // through the access and then fires a stray ack while idle.
    task automatic do_access(input logic st, input logic [15:0] b, input logic [3:0] imm,
                             input logic [15:0] sd, input logic [3:0] rd, input int waits,
                             input logic [15:0] rdv, input logic hold_start, input string tag);
        logic [15:0] exp_ea;
        int          req_cycles;
        bit          timed_out;
        exp_ea    = model_ea(b, imm);
        timed_out = (waits >= TO);
        start = 1'b1; is_store = st; base = b; imm4 = imm; st_data = sd; rd_addr = rd;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        base = 16'($urandom); imm4 = 4'($urandom); st_data = 16'($urandom); rd_addr = 4'($urandom);
        is_store = ~st;
        vectors++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s addr_phase: busy=%b mem_req=%b want busy=1 mem_req=0", tag, busy, mem_req);
        end
        req_cycles = 0;
        @(posedge clk); #1;
        while (mem_req === 1'b1 && req_cycles < TO + 2) begin
            vectors++;
            if (mem_addr !== exp_ea || mem_we !== st) begin
                miscompares++;
                $display("[TB] FAIL %s req_fields: addr=%h we=%b want addr=%h we=%b", tag, mem_addr, mem_we, exp_ea, st);
            end
            if (st) begin
                vectors++;
                if (mem_wdata !== sd) begin
                    miscompares++;
                    $display("[TB] FAIL %s req_wdata: got %h want %h", tag, mem_wdata, sd);
                end
            end
            req_cycles++;
            if (!timed_out && req_cycles == waits + 1) begin
                mem_ack = 1'b1; mem_rdata = rdv;
            end else begin
                mem_ack = 1'b0; mem_rdata = 16'($urandom);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (timed_out) begin
            vectors++;
            if (req_cycles != TO) begin
                miscompares++;
                $display("[TB] FAIL %s req_len: got %0d want %0d", tag, req_cycles, TO);
            end
            vectors++;
            if (err !== 1'b1 || done !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s abort: err=%b done=%b wb_en=%b busy=%b want 1 0 0 0", tag, err, done, wb_en, busy);
            end
            @(posedge clk); #1;
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s err_len: got %b want 0", tag, err);
            end
        end else begin
            vectors++;
            if (req_cycles != waits + 1) begin
                miscompares++;
                $display("[TB] FAIL %s req_len: got %0d want %0d", tag, req_cycles, waits + 1);
            end
            vectors++;
            if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || wb_en !== ~st) begin
                miscompares++;
                $display("[TB] FAIL %s done_cycle: done=%b busy=%b err=%b wb_en=%b want 1 1 0 %b", tag, done, busy, err, wb_en, ~st);
            end
            vectors++;
            if (wb_addr !== (st ? 4'd0 : rd) || wb_data !== (st ? 16'd0 : rdv)) begin
                miscompares++;
                $display("[TB] FAIL %s wb: addr=%h data=%h want addr=%h data=%h", tag, wb_addr, wb_data, st ? 4'd0 : rd, st ? 16'd0 : rdv);
            end
            vectors++;
            if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'd0 || mem_wdata !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL %s mem_idle: req=%b we=%b addr=%h wdata=%h want all 0", tag, mem_req, mem_we, mem_addr, mem_wdata);
            end
            @(posedge clk); #1;
            vectors++;
            if (done !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b0 || wb_data !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL %s after_done: done=%b wb_en=%b busy=%b wb_data=%h want 0 0 0 0", tag, done, wb_en, busy, wb_data);
            end
        end
        start = 1'b0;
        if (hold_start) begin
            mem_ack = 1'b1; mem_rdata = 16'hDEAD;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            vectors++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s stray: busy=%b req=%b done=%b wb_en=%b want 0 0 0 0", tag, busy, mem_req, done, wb_en);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wb_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: req=%b busy=%b done=%b err=%b wb_en=%b want all 0", mem_req, busy, done, err, wb_en);
        end
        vectors++;
        if (mem_addr !== 16'd0 || mem_wdata !== 16'd0 || wb_data !== 16'd0 || wb_addr !== 4'd0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_addr=%h we=%b want all 0", mem_addr, mem_wdata, wb_data, wb_addr, mem_we);
        end
        start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: busy=%b want 0", busy);
        end
        start = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        do_access(1'b0, 16'h0010, 4'hC, 16'h5555, 4'd5, 2, 16'hBEEF, 1'b0, "T1_load");
    endtask

    task automatic test_store();
        do_access(1'b1, 16'h1000, 4'h7, 16'h1234, 4'd9, 0, 16'hAAAA, 1'b0, "T2_store");
    endtask

    task automatic test_wrap();
        do_access(1'b0, 16'h0002, 4'h8, 16'h0000, 4'd1, 0, 16'h0F0F, 1'b0, "T3_wrap_neg");
        do_access(1'b0, 16'hFFFF, 4'h1, 16'h0000, 4'd2, 1, 16'hF0F0, 1'b0, "T3_wrap_pos");
    endtask

    task automatic test_timeout();
        do_access(1'b0, 16'h0400, 4'h3, 16'h0000, 4'd3, TO, 16'h0000, 1'b0, "T4_timeout");
        do_access(1'b1, 16'h0400, 4'hF, 16'hCAFE, 4'd3, 1, 16'h0000, 1'b0, "T4_recover");
        do_access(1'b0, 16'h2222, 4'h0, 16'h0000, 4'd7, TO - 1, 16'h7777, 1'b0, "T4_ack_at_limit");
    endtask

    task automatic test_start_held();
        do_access(1'b0, 16'h0300, 4'h4, 16'h0000, 4'd12, 1, 16'h4321, 1'b1, "T5_held");
    endtask

    task automatic test_reset_in_req();
        start = 1'b1; is_store = 1'b0; base = 16'h0010; imm4 = 4'hC; rd_addr = 4'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL T6_in_req: mem_req=%b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL T6_async: req=%b busy=%b addr=%h want 0 0 0", mem_req, busy, mem_addr);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 16'h0010, 4'hC, 16'h0000, 4'd6, 2, 16'hBEEF, 1'b0, "T6_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
            do_access(1'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 4'($urandom),
                      w, 16'($urandom), 1'b0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_wrap();
        test_timeout();
        test_start_held();
        test_reset_in_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
